sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Shares one sram-like slave port between the IF-stage instruction master (inst_sram_*)
//  and the MEM-stage data master (data_sram_*). Sits between the pipeline and the sram-like
//  to AXI bridge. Grants one address handshake per cycle with data-first priority and tracks
//  outstanding transactions in an in-order ID FIFO. Each data_ok is steered back to the issuing master.
// PARAMETERS
//  OUTSTANDING  4  max accepted-but-unanswered transactions (power of 2, >=2)
//  DATA_FIRST   1  1: data master wins a simultaneous new request; 0: instruction master wins
// PORTS
//  clk               in   1   clock, all state on posedge
//  resetn            in   1   asynchronous active-low reset
//  inst_req/wr       in   1   instruction master request / write flag
//  inst_size         in   2   transfer size
//  inst_addr         in   32  byte address
//  inst_wstrb        in   4   byte strobes
//  inst_wdata        in   32  write data
//  inst_addrok       out  1   address accepted for inst master
//  inst_dataok       out  1   response for inst master
//  inst_rdata        out  32  read data (= mem_rdata)
//  data_*            -    -   same nine signals for the data master
//  mem_req/wr        out  1   request / write flag to slave
//  mem_size          out  2   transfer size to slave
//  mem_addr          out  32  address to slave
//  mem_wstrb         out  4   byte strobes to slave
//  mem_wdata         out  32  write data to slave
//  mem_addrok        in   1   slave accepted address
//  mem_dataok        in   1   slave response (in issue order)
//  mem_rdata         in   32  slave read data
//  proto_err         out  1   sticky: mem_dataok seen with empty ID FIFO
// BEHAVIOUR
//  - Reset (resetn=0, async): ID FIFO empty, count=0, lock=0, owner=inst, proto_err=0.
//    All *_addrok, *_dataok and mem_req are therefore 0.
//  - full = (count==OUTSTANDING). When full: mem_req=0, both addrok=0. Requests stay pending.
//  - Arbitration (lock=0): pick data if data_req & (DATA_FIRST | ~inst_req), else inst if inst_req.
//  - Hold: if mem_req=1 & mem_addrok=0, set lock=1 and register owner.
//    While locked, the mux selects owner only; the other master sees addrok=0.
//    Lock clears on the cycle mem_addrok=1.
//  - Mux: mem_* = fields of selected master, combinational, no added latency.
//    mem_req = sel_req & ~full.
//  - addrok: sel_addrok = mem_addrok & mem_req for the selected master only; other master's addrok=0.
//  - Push: on mem_req & mem_addrok, push owner ID (0=inst, 1=data) into ID FIFO.
//  - Pop: on mem_dataok & ~empty, pop head.
//    head=0 -> inst_dataok=1; head=1 -> data_dataok=1; exactly one dataok per mem_dataok.
//  - Same-cycle push and pop: count unchanged, both pointers advance.
//    Pop is allowed when full; push the same cycle is blocked by full, so no overflow.
//  - Pointers are log2(OUTSTANDING) bits and wrap modulo OUTSTANDING.
//    count is log2(OUTSTANDING)+1 bits.
//  - mem_dataok with empty FIFO: no dataok to either master, proto_err<=1 (cleared only by reset).
//  - Combinational path mem_dataok -> *_dataok is permitted.
//  - No combinational path from *_req to mem_addrok is required.
//  - Reset mid-transaction: FIFO is dropped. Late slave responses then raise proto_err.
//    Slave and masters are reset together.
// TESTING
//  1 Single inst read: inst_req=1 addr=0xbfc00000, slave addrok next cycle -> mem_addr=0xbfc00000 held 2 cycles,
//    inst_addrok=1 once; slave dataok rdata=0x24010001 -> inst_dataok=1, data_dataok=0.
//  2 Simultaneous: inst_req & data_req same cycle, DATA_FIRST=1 -> data granted first, inst granted next cycle.
//    Responses returned in order data, inst.
//  3 Lock: inst_req, slave withholds addrok 3 cycles, data_req rises in cycle 2 ->
//    mem_addr stays inst addr until addrok, then data is issued.
//  4 Full: 4 inst reads accepted, no dataok -> count=4, mem_req=0 with a 5th request.
//    One dataok plus a new request the same cycle -> pop, next cycle push, count stays 4.
//  5 Wrap: 10 alternating inst/data transactions with random 0-3 cycle slave delays ->
//    every dataok routed to the matching issuer, pointers wrap twice.
//  6 Error / reset: mem_dataok with empty FIFO -> proto_err=1, no master dataok.
//    Async resetn pulse mid-transaction -> all outputs 0 immediately, proto_err=0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - data/instruction sram-like master arbiter with in-order response ID FIFO
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter bit DATA_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addrok,
  output logic        inst_dataok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addrok,
  output logic        data_dataok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addrok,
  input  logic        mem_dataok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int AW = $clog2(OUTSTANDING);
  localparam logic [AW:0] DEPTH = (AW + 1)'(OUTSTANDING);

  typedef enum logic [1:0] {IDLE, HOLD_INST, HOLD_DATA} state_t;

  state_t state_q, state_d;

  logic [OUTSTANDING-1:0] ids;
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [AW:0]            count;
  logic                   full;
  logic                   empty;
  logic                   sel_data;
  logic                   sel_req;
  logic                   push;
  logic                   pop;
  logic                   head;

  // Once an address is offered but not taken, the mux stays on that master until accepted.
  always_comb begin
    full  = (count == DEPTH);
    empty = (count == '0);
    case (state_q)
      HOLD_INST: sel_data = 1'b0;
      HOLD_DATA: sel_data = 1'b1;
      default:   sel_data = data_req & (DATA_FIRST | ~inst_req);
    endcase
    sel_req = sel_data ? data_req : inst_req;
  end

  always_comb begin
    state_d = state_q;
    if (mem_req) begin
      if (mem_addrok)    state_d = IDLE;
      else if (sel_data) state_d = HOLD_DATA;
      else               state_d = HOLD_INST;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign mem_req   = sel_req & ~full;
  assign mem_wr    = sel_data ? data_wr    : inst_wr;
  assign mem_size  = sel_data ? data_size  : inst_size;
  assign mem_addr  = sel_data ? data_addr  : inst_addr;
  assign mem_wstrb = sel_data ? data_wstrb : inst_wstrb;
  assign mem_wdata = sel_data ? data_wdata : inst_wdata;

  assign push = mem_req & mem_addrok;
  assign pop  = mem_dataok & ~empty;
  assign head = ids[rptr];

  assign inst_addrok = push & ~sel_data;
  assign data_addrok = push & sel_data;
  assign inst_dataok = pop & ~head;
  assign data_dataok = pop & head;
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;

  // ID 0 = instruction master, 1 = data master; responses return in issue order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ids       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) begin
        ids[wptr] <= sel_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_dataok && empty) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - randomized self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;

  localparam int OUT = 4;
  localparam bit DF  = 1'b1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addrok, inst_dataok, data_addrok, data_dataok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addrok, mem_dataok, proto_err;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING(OUT), .DATA_FIRST(DF)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addrok(inst_addrok),
    .inst_dataok(inst_dataok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addrok(data_addrok),
    .data_dataok(data_dataok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addrok(mem_addrok),
    .mem_dataok(mem_dataok), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: issuer of every accepted address, oldest first.
  bit exp_q[$];
  bit held, held_owner, exp_err;
  bit ipend, dpend;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    held = 0; held_owner = 0; exp_err = 0; ipend = 0; dpend = 0;
  endtask

  task automatic quiet_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addrok = 0; mem_dataok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    quiet_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic step(input int p_new, input int p_aok, input int p_dok, input bit force_dok);
    bit sel, ereq, grant, dok_valid, head;
    @(negedge clk);
    if (!ipend && $urandom_range(99) < p_new) begin
      ipend = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_addr = $urandom;
      inst_wstrb = 4'($urandom); inst_wdata = $urandom;
    end
    if (!dpend && $urandom_range(99) < p_new) begin
      dpend = 1; data_wr = 1'($urandom); data_size = 2'($urandom); data_addr = $urandom;
      data_wstrb = 4'($urandom); data_wdata = $urandom;
    end
    inst_req   = ipend;
    data_req   = dpend;
    mem_addrok = ($urandom_range(99) < p_aok);
    mem_dataok = force_dok || (exp_q.size() > 0 && $urandom_range(99) < p_dok);
    mem_rdata  = $urandom;
    #1;
    sel       = held ? held_owner : (dpend && (DF || !ipend));
    ereq      = (sel ? dpend : ipend) && (exp_q.size() < OUT);
    grant     = ereq && mem_addrok;
    dok_valid = mem_dataok && exp_q.size() > 0;
    head      = dok_valid ? exp_q[0] : 1'b0;
    check("mem_req", 72'(mem_req), 72'(ereq));
    check("inst_addrok", 72'(inst_addrok), 72'(grant && !sel));
    check("data_addrok", 72'(data_addrok), 72'(grant && sel));
    check("inst_dataok", 72'(inst_dataok), 72'(dok_valid && !head));
    check("data_dataok", 72'(data_dataok), 72'(dok_valid && head));
    check("rdata", {8'h0, inst_rdata, data_rdata}, {8'h0, mem_rdata, mem_rdata});
    check("proto_err", 72'(proto_err), 72'(exp_err));
    if (ereq)
      check("mem_fields", 72'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}),
            sel ? 72'({data_wr, data_size, data_wstrb, data_addr, data_wdata})
                : 72'({inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata}));
    if (dok_valid) void'(exp_q.pop_front());
    else if (mem_dataok) exp_err = 1;
    if (grant) begin
      exp_q.push_back(sel);
      if (sel) dpend = 0; else ipend = 0;
    end
    if (ereq) begin
      held       = !mem_addrok;
      held_owner = sel;
    end
    @(posedge clk);
  endtask

  initial begin
    do_reset();
    check("reset_mem_req", 72'(mem_req), 72'(0));
    check("reset_proto_err", 72'(proto_err), 72'(0));
    repeat (400) step(40, 70, 40, 0);
    repeat (300) step(70, 85, 8, 0);
    repeat (60)  step(0, 100, 100, 0);
    repeat (6)   step(0, 100, 0, 1);
    repeat (3)   step(0, 0, 0, 0);
    repeat (6)   step(70, 60, 0, 0);
    @(negedge clk);
    #2;
    resetn = 0;
    quiet_inputs();
    clear_model();
    #1;
    check("async_rst_mem_req", 72'(mem_req), 72'(0));
    check("async_rst_addrok", 72'({inst_addrok, data_addrok}), 72'(0));
    check("async_rst_dataok", 72'({inst_dataok, data_dataok}), 72'(0));
    check("async_rst_proto_err", 72'(proto_err), 72'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    repeat (200) step(50, 60, 50, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
